instr_fetch_decode: RTL

- Front end for the 3-bit-op register/immediate execution core.
- Fetches 32-bit RV32I words from a synchronous instruction memory and decodes OP-IMM instructions into the core's fields: opcode, rd, rs1 and imm12.
- Issues each decoded instruction over a valid/ready handshake, then advances the PC.
- Halts on ECALL/EBREAK or on an illegal encoding.

---
 rtl/instr_fetch_decode.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: reads RV32I words from a synchronous imem, decodes
// OP-IMM into opcode/rd/rs1/imm12, issues over valid/ready. Optional: IFD_SKIP_ILLEGAL_EN.
module instr_fetch_decode #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-3:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [2:0]            opcode,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [11:0]           imm12,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_e;

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]            opcode_q, opcode_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [11:0]           imm12_q, imm12_d;
  logic                  illegal_q, illegal_d;

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_sys;
  logic       is_legal_imm;

  assign funct3 = imem_data[14:12];
  assign funct7 = imem_data[31:25];
  assign is_sys = (imem_data == ECALL) || (imem_data == EBREAK);

  always_comb begin
    is_legal_imm = (imem_data[6:0] == OP_IMM);
    if (funct3 == 3'b001) begin
      is_legal_imm = is_legal_imm && (funct7 == 7'b0000000);
    end else if (funct3 == 3'b101) begin
      is_legal_imm = is_legal_imm && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_WIDTH'(RESET_PC);
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      imm12_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      imm12_q   <= imm12_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    imm12_d   = imm12_q;
`ifdef IFD_SKIP_ILLEGAL_EN
    illegal_d = 1'b0;
`else
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (is_legal_imm) begin
          opcode_d = funct3;
          rd_d     = imem_data[11:7];
          rs1_d    = imem_data[19:15];
          imm12_d  = imem_data[31:20];
          state_d  = S_ISSUE;
        end else if (is_sys) begin
          state_d = S_HALT;
        end else begin
          illegal_d = 1'b1;
`ifdef IFD_SKIP_ILLEGAL_EN
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_FETCH;
`else
          state_d = S_HALT;
`endif
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // Reset leaves the FSM in FETCH, so the strobe is gated to stay low while rst is held.
  assign imem_rd_en  = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q[ADDR_WIDTH-1:2];
  assign issue_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign opcode      = opcode_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign imm12       = imm12_q;
  assign pc          = pc_q;

endmodule
